// File: rtl/alu_pkg.sv
// Shared opcode encodings and flag-vector layout for the pipelined ALU.
// Build option ALU_PIPE_SHIFT_EN (see alu_core) enables SHL/SHR.
package alu_pkg;

    localparam int unsigned OP_W = 3;

    localparam logic [OP_W-1:0] OP_ADD = 3'b000;
    localparam logic [OP_W-1:0] OP_SUB = 3'b001;
    localparam logic [OP_W-1:0] OP_AND = 3'b010;
    localparam logic [OP_W-1:0] OP_OR  = 3'b011;
    localparam logic [OP_W-1:0] OP_XOR = 3'b100;
    localparam logic [OP_W-1:0] OP_ADC = 3'b101;
    localparam logic [OP_W-1:0] OP_SHL = 3'b110;
    localparam logic [OP_W-1:0] OP_SHR = 3'b111;

    localparam int unsigned FLAG_C = 0;
    localparam int unsigned FLAG_Z = 1;
    localparam int unsigned FLAG_N = 2;
    localparam int unsigned FLAG_V = 3;
    localparam int unsigned FLAG_E = 4;
    localparam int unsigned FLAG_W = 5;

endpackage

// File: rtl/alu_core.sv
// Combinational ALU datapath: result and C/Z/N/V/ERR flags from a, b, op, carry-in.
// ALU_PIPE_SHIFT_EN defined: SHL/SHR active; undefined: they report err with a zero result.
module alu_core
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  logic [WIDTH-1:0]  a_i,
    input  logic [WIDTH-1:0]  b_i,
    input  logic [OP_W-1:0]   op_i,
    input  logic              carry_i,
    output logic [WIDTH-1:0]  result_o,
    output logic [FLAG_W-1:0] flags_o
);

`ifdef ALU_PIPE_SHIFT_EN
    localparam int unsigned SHW = $clog2(WIDTH);
`endif

    logic [WIDTH-1:0] res;
    logic             c;
    logic             v;
    logic             err;

    always_comb begin
        res = '0;
        c   = 1'b0;
        v   = 1'b0;
        err = 1'b0;
        case (op_i)
            OP_ADD: begin
                {c, res} = {1'b0, a_i} + {1'b0, b_i};
                v = (a_i[WIDTH-1] == b_i[WIDTH-1]) && (res[WIDTH-1] != a_i[WIDTH-1]);
            end
            OP_SUB: begin
                // Top bit of the widened difference is the unsigned borrow.
                {c, res} = {1'b0, a_i} - {1'b0, b_i};
                v = (a_i[WIDTH-1] != b_i[WIDTH-1]) && (res[WIDTH-1] != a_i[WIDTH-1]);
            end
            OP_AND: res = a_i & b_i;
            OP_OR:  res = a_i | b_i;
            OP_XOR: res = a_i ^ b_i;
            OP_ADC: begin
                {c, res} = {1'b0, a_i} + {1'b0, b_i} + {{WIDTH{1'b0}}, carry_i};
                v = (a_i[WIDTH-1] == b_i[WIDTH-1]) && (res[WIDTH-1] != a_i[WIDTH-1]);
            end
`ifdef ALU_PIPE_SHIFT_EN
            // The extra bit beyond the result catches the last bit shifted out.
            OP_SHL: {c, res} = {1'b0, a_i} << b_i[SHW-1:0];
            OP_SHR: {res, c} = {a_i, 1'b0} >> b_i[SHW-1:0];
`else
            OP_SHL: err = 1'b1;
            OP_SHR: err = 1'b1;
`endif
            default: err = 1'b1;
        endcase
    end

    always_comb begin
        flags_o         = '0;
        flags_o[FLAG_C] = c;
        flags_o[FLAG_Z] = (res == '0);
        flags_o[FLAG_N] = res[WIDTH-1];
        flags_o[FLAG_V] = v;
        flags_o[FLAG_E] = err;
    end

    assign result_o = res;

endmodule

// File: rtl/alu_pipe.sv
// Two-stage valid/ready ALU pipeline with registered result/flags and a persistent carry flag.
// Shift ops depend on ALU_PIPE_SHIFT_EN (handled inside alu_core).
module alu_pipe
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic [OP_W-1:0]  in_op,
    input  logic             flag_clr,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_result,
    output logic             out_carry,
    output logic             out_zero,
    output logic             out_neg,
    output logic             out_ovf,
    output logic             out_err
);

    logic              s1_valid_q, s1_valid_d;
    logic [WIDTH-1:0]  s1_a_q, s1_a_d;
    logic [WIDTH-1:0]  s1_b_q, s1_b_d;
    logic [OP_W-1:0]   s1_op_q, s1_op_d;
    logic              out_valid_q, out_valid_d;
    logic [WIDTH-1:0]  res_q, res_d;
    logic [FLAG_W-1:0] flags_q, flags_d;
    logic              carry_q, carry_d;

    logic              accept;
    logic              s1_advance;
    logic [WIDTH-1:0]  core_res;
    logic [FLAG_W-1:0] core_flags;

    assign s1_advance = s1_valid_q && (!out_valid_q || out_ready);
    assign in_ready   = !s1_valid_q || s1_advance;
    assign accept     = in_valid && in_ready;

    alu_core #(
        .WIDTH(WIDTH)
    ) u_core (
        .a_i      (s1_a_q),
        .b_i      (s1_b_q),
        .op_i     (s1_op_q),
        .carry_i  (carry_q),
        .result_o (core_res),
        .flags_o  (core_flags)
    );

    always_comb begin
        s1_valid_d  = s1_valid_q;
        s1_a_d      = s1_a_q;
        s1_b_d      = s1_b_q;
        s1_op_d     = s1_op_q;
        out_valid_d = out_valid_q;
        res_d       = res_q;
        flags_d     = flags_q;
        carry_d     = carry_q;

        if (accept) begin
            s1_valid_d = 1'b1;
            s1_a_d     = in_a;
            s1_b_d     = in_b;
            s1_op_d    = in_op;
        end else if (s1_advance) begin
            s1_valid_d = 1'b0;
        end

        // Carry follows stage-2 load order, so an ADC in stage 1 always sees its predecessor.
        if (s1_advance) begin
            out_valid_d = 1'b1;
            res_d       = core_res;
            flags_d     = core_flags;
            carry_d     = core_flags[FLAG_C];
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end

        if (flag_clr) begin
            carry_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid_q  <= 1'b0;
            s1_a_q      <= '0;
            s1_b_q      <= '0;
            s1_op_q     <= '0;
            out_valid_q <= 1'b0;
            res_q       <= '0;
            flags_q     <= '0;
            carry_q     <= 1'b0;
        end else begin
            s1_valid_q  <= s1_valid_d;
            s1_a_q      <= s1_a_d;
            s1_b_q      <= s1_b_d;
            s1_op_q     <= s1_op_d;
            out_valid_q <= out_valid_d;
            res_q       <= res_d;
            flags_q     <= flags_d;
            carry_q     <= carry_d;
        end
    end

    assign out_valid  = out_valid_q;
    assign out_result = res_q;
    assign out_carry  = flags_q[FLAG_C];
    assign out_zero   = flags_q[FLAG_Z];
    assign out_neg    = flags_q[FLAG_N];
    assign out_ovf    = flags_q[FLAG_V];
    assign out_err    = flags_q[FLAG_E];

endmodule

// File: tb/tb_alu_pipe.sv
// Scoreboard bench for alu_pipe (WIDTH=8): directed cases plus random traffic vs. an arithmetic model.
// Expected shift behaviour follows ALU_PIPE_SHIFT_EN, matching the RTL build.
module tb_alu_pipe;

    typedef struct packed {
        logic [7:0] res;
        logic       c;
        logic       z;
        logic       n;
        logic       v;
        logic       err;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_a;
    logic [7:0] in_b;
    logic [2:0] in_op;
    logic       flag_clr;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_result;
    logic       out_carry;
    logic       out_zero;
    logic       out_neg;
    logic       out_ovf;
    logic       out_err;

    int   checks = 0;
    int   passes = 0;
    exp_t exp_q[$];
    bit   model_carry = 1'b0;
    bit   rand_bp = 1'b0;
    bit   hold_prev = 1'b0;
    logic [12:0] hold_val;

    alu_pipe #(
        .WIDTH(8)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_a       (in_a),
        .in_b       (in_b),
        .in_op      (in_op),
        .flag_clr   (flag_clr),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_result (out_result),
        .out_carry  (out_carry),
        .out_zero   (out_zero),
        .out_neg    (out_neg),
        .out_ovf    (out_ovf),
        .out_err    (out_err)
    );

    always #5 clk = ~clk;

    function automatic logic [12:0] dut_out();
        return {out_result, out_carry, out_zero, out_neg, out_ovf, out_err};
    endfunction

    function automatic exp_t mk(input logic [7:0] r, input bit c, z, n, v, e);
        exp_t t;
        t.res = r; t.c = c; t.z = z; t.n = n; t.v = v; t.err = e;
        return t;
    endfunction

    // Reference model: plain integer arithmetic with signed range checks for overflow.
    function automatic exp_t model(input logic [2:0] op, input logic [7:0] a8, b8, input bit cin);
        int   a, b, sa, sb, full, sfull, amt;
        exp_t e;
        a = int'(a8);
        b = int'(b8);
        sa = (a >= 128) ? a - 256 : a;
        sb = (b >= 128) ? b - 256 : b;
        e = '0;
        full = 0;
        amt = b % 8;
        case (op)
            3'd0: begin
                full = a + b; sfull = sa + sb;
                e.c = (full > 255); e.v = (sfull > 127) || (sfull < -128);
            end
            3'd1: begin
                full = a - b; sfull = sa - sb;
                e.c = (a < b); e.v = (sfull > 127) || (sfull < -128);
            end
            3'd2: full = a & b;
            3'd3: full = a | b;
            3'd4: full = a ^ b;
            3'd5: begin
                full = a + b + int'(cin); sfull = sa + sb + int'(cin);
                e.c = (full > 255); e.v = (sfull > 127) || (sfull < -128);
            end
`ifdef ALU_PIPE_SHIFT_EN
            3'd6: begin
                full = a * (2 ** amt);
                e.c = (amt > 0) && ((full / 256) % 2 == 1);
            end
            3'd7: begin
                full = a / (2 ** amt);
                e.c = (amt > 0) && ((a / (2 ** (amt - 1))) % 2 == 1);
            end
`else
            default: begin
                full = 0; e.err = 1'b1;
            end
`endif
        endcase
        full = ((full % 256) + 256) % 256;
        e.res = 8'(full);
        e.z = (full == 0);
        e.n = (full >= 128);
        return e;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act === req) passes++;
        else $display("FAIL %s: got %0h, required %0h", name, act, req);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        if (rand_bp) out_ready = ($urandom_range(0, 3) != 0);
    endtask

    task automatic issue(input logic [2:0] op, input logic [7:0] a, b,
                         input bit use_exp, input exp_t req);
        exp_t e;
        int   waited = 0;
        in_valid = 1'b1; in_op = op; in_a = a; in_b = b;
        forever begin
            @(negedge clk);
            if (in_ready) break;
            tick();
            waited++;
            if (waited > 200) begin
                checks++;
                $display("FAIL accept_timeout: in_ready stuck at 0, required 1");
                in_valid = 1'b0;
                return;
            end
        end
        @(posedge clk);
        e = model(op, a, b, model_carry);
        model_carry = e.c;
        exp_q.push_back(use_exp ? req : e);
        #1;
        in_valid = 1'b0;
        if (rand_bp) out_ready = ($urandom_range(0, 3) != 0);
    endtask

    task automatic drain();
        int n = 0;
        while ((exp_q.size() != 0 || out_valid) && n < 200) begin
            tick();
            n++;
        end
        checks++;
        if (exp_q.size() == 0 && !out_valid) passes++;
        else $display("FAIL drain_timeout: %0d results outstanding, required 0", exp_q.size());
    endtask

    task automatic pulse_clr();
        flag_clr = 1'b1;
        tick();
        flag_clr = 1'b0;
        model_carry = 1'b0;
    endtask

    function automatic logic [7:0] pick();
        case ($urandom_range(0, 7))
            0: return 8'h00;
            1: return 8'h01;
            2: return 8'h7F;
            3: return 8'h80;
            4: return 8'hFF;
            default: return 8'($urandom);
        endcase
    endfunction

    // Monitor: holds must be stable; every delivered beat pops one expectation.
    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            hold_prev = 1'b0;
        end else begin
            if (hold_prev) begin
                checks++;
                if (dut_out() === hold_val) passes++;
                else $display("FAIL hold_stable: got %0h, required %0h", dut_out(), hold_val);
            end
            hold_prev = out_valid && !out_ready;
            hold_val  = dut_out();
            if (out_valid && out_ready) begin
                checks++;
                if (exp_q.size() == 0) begin
                    $display("FAIL unexpected_beat: got res=%0h, required no beat", out_result);
                end else begin
                    e = exp_q.pop_front();
                    if (dut_out() === 13'(e)) passes++;
                    else $display("FAIL result: got res=%0h c%0b z%0b n%0b v%0b e%0b, required res=%0h c%0b z%0b n%0b v%0b e%0b",
                                  out_result, out_carry, out_zero, out_neg, out_ovf, out_err,
                                  e.res, e.c, e.z, e.n, e.v, e.err);
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; in_valid = 1'b0; in_a = '0; in_b = '0; in_op = '0;
        flag_clr = 1'b0; out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_valid", 32'(out_valid), 0);
        chk("reset_outputs", 32'(dut_out()), 0);
        chk("reset_in_ready", 32'(in_ready), 1);
        rst = 1'b0;
        tick();

        // Test 1: latency and wrap to zero with carry.
        issue(3'd0, 8'hFF, 8'h01, 1, mk(8'h00, 1, 1, 0, 0, 0));
        chk("lat_first_edge", 32'(out_valid), 0);
        tick();
        chk("lat_second_edge", 32'(out_valid), 1);
        drain();

        // Test 2: subtraction borrow and signed overflow.
        issue(3'd1, 8'h05, 8'h07, 1, mk(8'hFE, 1, 0, 1, 0, 0));
        issue(3'd1, 8'h80, 8'h01, 1, mk(8'h7F, 0, 0, 0, 1, 0));
        drain();

        // Test 3: carry chain, then carry cleared between the pair.
        issue(3'd0, 8'hFF, 8'h01, 1, mk(8'h00, 1, 1, 0, 0, 0));
        issue(3'd5, 8'h00, 8'h00, 1, mk(8'h01, 0, 0, 0, 0, 0));
        drain();
        issue(3'd0, 8'hFF, 8'h01, 1, mk(8'h00, 1, 1, 0, 0, 0));
        drain();
        pulse_clr();
        issue(3'd5, 8'h00, 8'h00, 1, mk(8'h00, 0, 1, 0, 0, 0));
        drain();

        // Test 4: backpressure fills both stages, then releases in order.
        out_ready = 1'b0;
        issue(3'd0, 8'h10, 8'h20, 0, '0);
        issue(3'd1, 8'h30, 8'h40, 0, '0);
        chk("bp_in_ready_low", 32'(in_ready), 0);
        fork
            issue(3'd4, 8'hAA, 8'h55, 0, '0);
            begin
                repeat (6) begin
                    tick();
                    chk("bp_in_ready_held", 32'(in_ready), 0);
                end
                out_ready = 1'b1;
            end
        join
        issue(3'd3, 8'h0F, 8'hF0, 0, '0);
        drain();

        // Test 5: asynchronous reset with beats in flight.
        out_ready = 1'b0;
        issue(3'd0, 8'hFF, 8'h01, 0, '0);
        issue(3'd0, 8'h12, 8'h34, 0, '0);
        #2;
        rst = 1'b1;
        #1;
        chk("async_rst_valid", 32'(out_valid), 0);
        chk("async_rst_outputs", 32'(dut_out()), 0);
        exp_q.delete();
        model_carry = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        out_ready = 1'b1;
        tick();
        issue(3'd0, 8'hFF, 8'h01, 1, mk(8'h00, 1, 1, 0, 0, 0));
        chk("post_rst_lat_first", 32'(out_valid), 0);
        tick();
        chk("post_rst_lat_second", 32'(out_valid), 1);
        drain();

        // Test 6: shift left with the bit shifted out.
`ifdef ALU_PIPE_SHIFT_EN
        issue(3'd6, 8'h81, 8'h01, 1, mk(8'h02, 1, 0, 0, 0, 0));
`else
        issue(3'd6, 8'h81, 8'h01, 1, mk(8'h00, 0, 1, 0, 0, 1));
`endif
        drain();

        // Random traffic with random backpressure and occasional carry clears.
        rand_bp = 1'b1;
        for (int i = 0; i < 300; i++) begin
            if ($urandom_range(0, 15) == 0) begin
                drain();
                pulse_clr();
            end
            issue(3'($urandom_range(0, 7)), pick(), pick(), 0, '0);
            if ($urandom_range(0, 3) == 0) tick();
        end
        rand_bp = 1'b0;
        out_ready = 1'b1;
        drain();

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
